// File: rtl/byte_pack16.sv
// Byte-to-word packer: pairs bytes into 16-bit words with byte sum and pad flag,
// buffered in a first-word fall-through FIFO.
module byte_pack16 #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_data,
  output logic [8:0]                 out_sum,
  output logic                       out_odd,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {EMPTY, HALF} state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [8:0]  sum;
    logic        odd;
  } entry_t;

  state_t        state;
  logic [7:0]    hi;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] cnt;

  logic   accept;
  logic   pop;
  logic   push;
  entry_t push_e;
  entry_t head;

  assign in_ready  = (cnt != FULL) & res;
  assign out_valid = (cnt != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign level     = cnt;

  assign head     = mem[rptr];
  assign out_data = head.data;
  assign out_sum  = head.sum;
  assign out_odd  = head.odd;

  always_comb begin
    push   = 1'b0;
    push_e = '0;
    if (accept) begin
      unique case (1'b1)
        (state == HALF): begin
          push        = 1'b1;
          push_e.data = {hi, in_data};
          push_e.sum  = {1'b0, hi} + {1'b0, in_data};
          push_e.odd  = 1'b0;
        end
        (state == EMPTY && in_last): begin
          push        = 1'b1;
          push_e.data = {in_data, 8'h00};
          push_e.sum  = {1'b0, in_data};
          push_e.odd  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= EMPTY;
      hi    <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (accept) begin
        unique case (state)
          EMPTY: begin
            if (!in_last) begin
              hi    <= in_data;
              state <= HALF;
            end
          end
          HALF: state <= EMPTY;
          default: state <= EMPTY;
        endcase
      end
      if (push) begin
        mem[wptr] <= push_e;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (!push && pop) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule
